// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: request/ack handshake and register-bank write bus of the write arbiter
interface regfile_write_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int NREQ = 3,
  parameter int NREG = 16,
  parameter int AW = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic flush;
  logic [NREG-1:0] wr;
  logic [WIDTH-1:0] D;
  logic bank_clr;
  logic addr_err;
  modport master(output req, req_addr, req_data, flush, input ack, wr, D, bank_clr, addr_err);
  modport slave(input req, req_addr, req_data, flush, output ack, wr, D, bank_clr, addr_err);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register-bank write path among execution units
module regfile_write_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ = 3,
  parameter int NREG = 16,
  parameter int AW = 4
) (
  input logic clk,
  input logic clr,
  regfile_write_arbiter_if.slave b
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, w, j;
  logic hit, grant;
  logic [AW-1:0] a;
  logic [WIDTH-1:0] d;
  // scan from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    w = ptr;
    j = '0;
    hit = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (b.req[j]) begin
        w = j;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    a = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++)
      if (PW'(i) == w) begin
        a = b.req_addr[i*AW +: AW];
        d = b.req_data[i*WIDTH +: WIDTH];
      end
  end
  assign grant = hit && !clr && !b.flush;
  assign b.ack = grant ? NREQ'(1) << w : '0;
  always_ff @(posedge clk)
    if (clr) begin
      ptr <= PW'(NREQ - 1);
      b.wr <= '0;
      b.D <= '0;
      b.bank_clr <= 1'b0;
      b.addr_err <= 1'b0;
    end else begin
      b.bank_clr <= b.flush;
      b.wr <= grant && int'(a) < NREG ? NREG'(1) << a : '0;
      b.addr_err <= grant && int'(a) >= NREG;
      if (grant) begin
        ptr <= w;
        b.D <= d;
      end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of grant order, write path, flush, address range and reset
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic flush = 1'b0;
  logic [2:0] req = '0;
  logic [11:0] ra = '0;
  logic [191:0] rd = '0;
  int total = 0;
  int passed = 0;
  logic [15:0] rr_wr [3] = '{16'h0002, 16'h0004, 16'h0008};
  logic [63:0] rr_d [3] = '{64'hA, 64'hB, 64'hC};

  regfile_write_arbiter_if ia ();
  regfile_write_arbiter_if #(.NREG(12)) ib ();

  assign ia.req = req;
  assign ia.req_addr = ra;
  assign ia.req_data = rd;
  assign ia.flush = flush;
  assign ib.req = req;
  assign ib.req_addr = ra;
  assign ib.req_data = rd;
  assign ib.flush = flush;

  regfile_write_arbiter dut_a (.clk(clk), .clr(clr), .b(ia.slave));
  regfile_write_arbiter #(.NREG(12)) dut_b (.clk(clk), .clr(clr), .b(ib.slave));

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h", t, o, e);
  endtask

  initial begin
    @(negedge clk);
    clr = 1'b1; req = 3'b111; flush = 1'b1;
    #1 chk("ack_in_clr", 64'(ia.ack), 64'h0);
    @(posedge clk); #1;
    chk("rst_bank_clr", 64'(ia.bank_clr), 64'h0);
    chk("rst_wr", 64'(ia.wr), 64'h0);
    chk("rst_d", ia.D, 64'h0);
    chk("rst_addr_err", 64'(ib.addr_err), 64'h0);
    @(negedge clk);
    clr = 1'b0; flush = 1'b0; req = 3'b001; ra = 12'h005; rd[63:0] = 64'h0006_0000_0003;
    #1 chk("single_ack", 64'(ia.ack), 64'h1);
    @(posedge clk); #1;
    chk("single_wr", 64'(ia.wr), 64'h0020);
    chk("single_d", ia.D, 64'h0006_0000_0003);
    chk("single_addr_err", 64'(ia.addr_err), 64'h0);
    @(negedge clk);
    req = '0; clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; req = 3'b111; ra = 12'h321; rd = {64'hC, 64'hB, 64'hA};
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ack", 64'(ia.ack), 64'(3'b001 << (i % 3)));
      @(posedge clk); #1;
      chk("rr_wr", 64'(ia.wr), 64'(rr_wr[i % 3]));
      chk("rr_d", ia.D, rr_d[i % 3]);
      @(negedge clk);
    end
    req = '0;
    #1 chk("idle_ack", 64'(ia.ack), 64'h0);
    @(posedge clk); #1;
    chk("idle_wr", 64'(ia.wr), 64'h0);
    chk("idle_d_hold", ia.D, 64'hC);
    @(negedge clk);
    req = 3'b010;
    for (int i = 0; i < 3; i++) begin
      ra[7:4] = 4'(i + 2); rd[127:64] = 64'h100 + 64'(i);
      #1 chk("b2b_ack", 64'(ia.ack), 64'h2);
      @(posedge clk); #1;
      chk("b2b_wr", 64'(ia.wr), 64'h0004 << i);
      chk("b2b_d", ia.D, 64'h100 + 64'(i));
      @(negedge clk);
    end
    flush = 1'b1; req = 3'b100; ra[11:8] = 4'd7; rd[191:128] = 64'hF00D;
    #1 chk("flush_ack", 64'(ia.ack), 64'h0);
    @(posedge clk); #1;
    chk("flush_bank_clr", 64'(ia.bank_clr), 64'h1);
    chk("flush_wr", 64'(ia.wr), 64'h0);
    chk("flush_d_hold", ia.D, 64'h102);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("post_flush_ack", 64'(ia.ack), 64'h4);
    @(posedge clk); #1;
    chk("post_flush_bank_clr", 64'(ia.bank_clr), 64'h0);
    chk("post_flush_wr", 64'(ia.wr), 64'h0080);
    chk("post_flush_d", ia.D, 64'hF00D);
    @(negedge clk);
    req = 3'b001; ra[3:0] = 4'd13; rd[63:0] = 64'hBAD;
    #1 chk("oor_ack", 64'(ib.ack), 64'h1);
    @(posedge clk); #1;
    chk("oor_wr", 64'(ib.wr), 64'h0);
    chk("oor_addr_err", 64'(ib.addr_err), 64'h1);
    chk("oor_d", ib.D, 64'hBAD);
    chk("inrange_wr", 64'(ia.wr), 64'h2000);
    chk("inrange_addr_err", 64'(ia.addr_err), 64'h0);
    @(negedge clk);
    req = 3'b011; ra[7:4] = 4'd1;
    #1 chk("oor_ptr_adv_ack", 64'(ib.ack), 64'h2);
    @(posedge clk); #1;
    chk("oor_err_clears", 64'(ib.addr_err), 64'h0);
    chk("oor_next_wr", 64'(ib.wr), 64'h002);
    @(negedge clk);
    req = 3'b111;
    #1 chk("mid_ack", 64'(ia.ack), 64'h4);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1 chk("mid_clr_ack", 64'(ia.ack), 64'h0);
    @(posedge clk); #1;
    chk("mid_clr_wr", 64'(ia.wr), 64'h0);
    chk("mid_clr_d", ia.D, 64'h0);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("after_clr_ack", 64'(ia.ack), 64'h1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter sharing the single write path of the general-purpose register bank (NREG instances of the 64-bit register with D/wr/clr) between NREQ execution units (ALU, load unit, multiplier). It accepts one write per cycle from a request/acknowledge handshake and drives a registered one-hot write-enable vector and a broadcast data bus into the bank. A flush command clears the whole bank through the bank's clear inputs.

## Interface
- WIDTH, 64, register data width
- NREQ, 3, number of requesters
- NREG, 16, number of registers in the bank
- AW, 4, register address width
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  synchronous active-high reset
- req  in  NREQ  write request per requester, held until acknowledged
- req_addr  in  NREQ*AW  target register; requester i at [i*AW +: AW]
- req_data  in  NREQ*WIDTH  write data; requester i at [i*WIDTH +: WIDTH]
- flush  in  1  clear entire bank; blocks grants in the same cycle
- ack  out  NREQ  combinational one-hot grant; transfer occurs at the edge ending a cycle with ack[i]=1
- wr  out  NREG  registered one-hot write enables to the bank
- D  out  WIDTH  registered write data to the bank
- bank_clr  out  1  registered clear pulse to all bank clr inputs
- addr_err  out  1  registered pulse: granted address >= NREG

## Operation
- State: ptr (last granted index, log2(NREQ) bits), output registers wr, D, bank_clr, addr_err.
- Grant search order: ptr+1, ptr+2, …, ptr+NREQ, modulo NREQ; first index with req=1 wins (w).
- ack = one-hot(w) when any req=1, clr=0, flush=0; else all zero. At most one ack bit high.
- At edge with a grant: ptr <= w; D <= req_data[w]; wr <= one-hot(req_addr[w]) if req_addr[w] < NREG, else wr <= 0 and addr_err <= 1. Out-of-range request is still acknowledged and consumed.
- At edge with no grant: wr <= 0, addr_err <= 0, D holds its value, ptr holds.
- flush=1 (clr=0): bank_clr <= 1 for each cycle flush is high, wr <= 0, no ack, ptr holds. Pending requests stay pending and are granted after flush drops.
- Requesters sample ack at the rising edge; on ack they drop req or present the next write in the following cycle. A requester may keep req high for back-to-back writes; with other requesters active it is granted no more than once every NREQ cycles while others wait.
- Two requesters targeting the same register: writes land in grant order; later grant wins in the bank.
- Fairness: any requester holding req is granted within NREQ cycles of assertion unless flush/clr is active.

## Timing
- Reset (clr=1 at edge): ptr <= NREQ-1 (requester 0 first priority), wr <= 0, D <= 0, bank_clr <= 0, addr_err <= 0; ack forced 0 while clr=1. clr mid-handshake: request not accepted; requester must hold req after reset.
- Grant latency: 0 cycles (ack combinational in the cycle req is seen).
- Write latency: req/ack in cycle c -> wr/D valid in cycle c+1 -> bank Q updated in cycle c+2.
- Throughput: one write per cycle total.
- flush in cycle c -> bank_clr high in c+1 -> bank Q = 0 from c+2.
- clr dominates flush; flush dominates req.

## Test plan
- Reset then single write: req=001, addr0=5, data0=64'h0006_0000_0003 -> ack=001 same cycle; next cycle wr=16'h0020, D=64'h0006_0000_0003; addr_err=0.
- Round-robin: all req=111 held for 6 cycles after reset -> ack sequence 001,010,100,001,010,100; wr follows each requester's address one cycle later.
- Back-to-back single requester: req=010 for 3 cycles, addr1=2,3,4 -> ack=010 every cycle; wr=0x0004,0x0008,0x0010 on consecutive cycles.
- Flush vs request: flush=1 and req=100 same cycle -> ack=000, next cycle bank_clr=1, wr=0; flush drops -> ack=100 following cycle.
- Out-of-range with NREG=12: req=001, addr0=13 -> ack=001; next cycle wr=0, addr_err=1; ptr advances to 0.
- Reset mid-stream: req=111 granting, clr=1 for one cycle -> ack=000 during clr, wr=0 and D=0 after edge, first grant after reset goes to requester 0.
